// File: rtl/lfsr_prbs_burst_ctrl.sv
//------------------------------------------------------------------------------
// lfsr_prbs_burst_ctrl
//
// Turns the free-running output of an external lfsr_prbs generator into
// finite AXI-stream bursts. The controller reseeds and primes the generator,
// advances it only on accepted beats, marks the final beat, and reports
// completion. Backpressure never skips or repeats a word.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           single-cycle burst request (sampled in IDLE only)
//   burst_len       words in the burst, captured with start
//   abort           terminate the current burst early
//   prbs_rst        synchronous reset to the generator
//   prbs_enable     advance the generator by one word
//   prbs_data       generator data_out
//   m_axis_*        AXI-stream master (tdata/tvalid/tready/tlast)
//   busy            high whenever the controller is not idle
//   done            one-cycle pulse at the end of a burst
//   aborted         status of the last burst, valid from done until next start
//   word_count      beats accepted in the current/last burst
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module lfsr_prbs_burst_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter bit          RESEED     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  abort,
    output logic                  prbs_rst,
    output logic                  prbs_enable,
    input  logic [DATA_WIDTH-1:0] prbs_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_PRIME,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] len_q, len_nxt;
    logic [LEN_WIDTH-1:0] count_q, count_nxt;
    logic                 primed_q, primed_nxt;
    logic                 abort_q, abort_nxt;
    logic                 aborted_q, aborted_nxt;
    // Holds the generator in reset while the controller is in reset and for
    // the remainder of that cycle; clears on the first clock after release.
    logic                 gen_hold;
    logic                 show_last;

    // tlast is a decode of registered state only; a latched abort never sets
    // abort_q while tlast is already showing, so tlast cannot drop mid-stall.
    assign show_last = (state == S_SEND) && (count_q == len_q - ONE) && !abort_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            count_q   <= '0;
            primed_q  <= 1'b0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
            gen_hold  <= 1'b1;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            count_q   <= count_nxt;
            primed_q  <= primed_nxt;
            abort_q   <= abort_nxt;
            aborted_q <= aborted_nxt;
            gen_hold  <= 1'b0;
        end
    end

    always_comb begin
        state_nxt     = state;
        len_nxt       = len_q;
        count_nxt     = count_q;
        primed_nxt    = primed_q;
        abort_nxt     = abort_q;
        aborted_nxt   = aborted_q;

        prbs_rst      = gen_hold;
        prbs_enable   = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        busy          = (state != S_IDLE);
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    len_nxt     = burst_len;
                    count_nxt   = '0;
                    aborted_nxt = 1'b0;
                    abort_nxt   = 1'b0;
                    if (burst_len == '0) begin
                        state_nxt = S_DONE;
                    end else if (RESEED || !primed_q) begin
                        state_nxt = S_SEED;
                    end else begin
                        state_nxt = S_SEND;
                    end
                end
            end

            S_SEED: begin
                prbs_rst = 1'b1;
                if (abort) begin
                    aborted_nxt = 1'b1;
                    primed_nxt  = 1'b0;
                    state_nxt   = S_DONE;
                end else begin
                    state_nxt = S_PRIME;
                end
            end

            S_PRIME: begin
                prbs_enable = 1'b1;
                if (abort) begin
                    // Generator state is undefined after a cut-short prime.
                    aborted_nxt = 1'b1;
                    primed_nxt  = 1'b0;
                    state_nxt   = S_DONE;
                end else begin
                    primed_nxt = 1'b1;
                    state_nxt  = S_SEND;
                end
            end

            S_SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = prbs_data;
                m_axis_tlast  = show_last;
                if (m_axis_tready) begin
                    prbs_enable = 1'b1;
                    count_nxt   = count_q + ONE;
                    if (show_last) begin
                        state_nxt = S_DONE;
                    end else if (abort || abort_q) begin
                        aborted_nxt = 1'b1;
                        state_nxt   = S_DONE;
                    end
                end else if (abort && !show_last) begin
                    abort_nxt = 1'b1;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign aborted    = aborted_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_lfsr_prbs_burst_ctrl.sv
//------------------------------------------------------------------------------
// tb_lfsr_prbs_burst_ctrl
//
// Two controllers (RESEED=0 at index 0, RESEED=1 at index 1) each driving a
// word-indexed generator stub. Expected data is word k of a bit-serial PRBS31
// stream, 64 bits per word, where k follows the burst rules: restart at 0 on
// every reseed, otherwise continue from the number of accepted beats so far.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lfsr_prbs_burst_ctrl;

    localparam int DW = 64;
    localparam int LW = 16;
    localparam int NW = 512;
    localparam logic [DW-1:0] SEED_WORD = 64'hA5A5_5A5A_0F0F_F0F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          start, abort, tready;
    logic [1:0][LW-1:0]  blen;
    logic [1:0]          prbs_rst, prbs_en, tvalid, tlast, busy, done, aborted;
    logic [1:0][DW-1:0]  prbs_data, tdata;
    logic [1:0][LW-1:0]  wc;

    logic [DW-1:0] words [NW];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            lfsr_prbs_burst_ctrl #(
                .DATA_WIDTH (DW),
                .LEN_WIDTH  (LW),
                .RESEED     (g == 1)
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .start         (start[g]),
                .burst_len     (blen[g]),
                .abort         (abort[g]),
                .prbs_rst      (prbs_rst[g]),
                .prbs_enable   (prbs_en[g]),
                .prbs_data     (prbs_data[g]),
                .m_axis_tdata  (tdata[g]),
                .m_axis_tvalid (tvalid[g]),
                .m_axis_tready (tready[g]),
                .m_axis_tlast  (tlast[g]),
                .busy          (busy[g]),
                .done          (done[g]),
                .aborted       (aborted[g]),
                .word_count    (wc[g])
            );

            // Generator stub: after reset it shows the seed, each enable
            // moves to the next word of the sequence.
            int gidx = -1;
            always @(posedge clk) begin
                if (prbs_rst[g]) gidx <= -1;
                else if (prbs_en[g]) gidx <= gidx + 1;
            end
            assign prbs_data[g] = (gidx >= 0 && gidx < NW) ? words[gidx] : SEED_WORD;
        end
    endgenerate

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int next_idx [2];
    bit primed_m [2];

    typedef struct {
        int sel;
        int len;
        int pct;
        int abort_after;
        int exp_wc;
        bit exp_ab;
        bit exp_seed;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_words();
        logic [30:0] s;
        logic        b;
        s = '1;
        for (int w = 0; w < NW; w++) begin
            for (int i = DW - 1; i >= 0; i--) begin
                b = s[30] ^ s[27];
                s = {s[29:0], b};
                words[w][i] = b;
            end
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        start  = '0;
        abort  = '0;
        tready = '0;
        blen   = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_prbs_rst", 64'(prbs_rst[s]), 64'd1);
            check("rst_tvalid",   64'(tvalid[s]),   64'd0);
            check("rst_tlast",    64'(tlast[s]),    64'd0);
            check("rst_busy",     64'(busy[s]),     64'd0);
            check("rst_done",     64'(done[s]),     64'd0);
            check("rst_aborted",  64'(aborted[s]),  64'd0);
            check("rst_wc",       64'(wc[s]),       64'd0);
            check("rst_prbs_en",  64'(prbs_en[s]),  64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) check("rel_prbs_rst", 64'(prbs_rst[s]), 64'd0);
        primed_m[0] = 1'b0; primed_m[1] = 1'b0;
        next_idx[0] = 0;    next_idx[1] = 0;
    endtask

    // Runs one burst on controller sel and checks it against the model.
    task automatic run_burst(input int sel, input int len, input int pct,
                             input int abort_after, input int exp_wc,
                             input bit exp_ab, input bit exp_seed);
        int  start_idx, hs, rel, first_v, done_rel, last_hs;
        bit  saw_seed, abort_sent;
        bit  exp_last;
        start_idx  = (sel == 1 || !primed_m[sel]) ? 0 : next_idx[sel];
        hs = 0; first_v = -1; done_rel = -1; last_hs = 0;
        saw_seed = 1'b0; abort_sent = 1'b0;

        tready[sel] = 1'b0;
        start[sel]  = 1'b1;
        blen[sel]   = LW'(len);
        @(negedge clk);
        start[sel] = 1'b0;
        rel = 1;
        while (rel < 2000) begin
            if (prbs_rst[sel]) saw_seed = 1'b1;
            abort[sel] = 1'b0;
            start[sel] = 1'b0;
            if (done[sel]) begin
                done_rel = rel;
                break;
            end
            if (tvalid[sel]) begin
                if (first_v < 0) first_v = rel;
                exp_last = (hs == len - 1) && !abort_sent;
                check("tdata", tdata[sel], words[start_idx + hs]);
                check("tlast", 64'(tlast[sel]), 64'(exp_last));
                // Requests while busy must be ignored.
                start[sel] = 1'($urandom_range(1));
                blen[sel]  = LW'($urandom_range(50));
                if (abort_after >= 0 && !abort_sent && hs == abort_after) begin
                    tready[sel] = 1'b0;
                    abort[sel]  = 1'b1;
                    abort_sent  = 1'b1;
                end else begin
                    tready[sel] = ($urandom_range(99) < pct);
                end
                #1;
                if (tready[sel]) begin
                    if (tlast[sel]) last_hs++;
                    hs++;
                end
            end else begin
                tready[sel] = 1'($urandom_range(1));
            end
            @(negedge clk);
            rel++;
        end
        tready[sel] = 1'b0;
        abort[sel]  = 1'b0;
        start[sel]  = 1'b0;

        check("done_seen",   64'(done_rel > 0), 64'd1);
        check("handshakes",  64'(hs),           64'(exp_wc));
        check("word_count",  64'(wc[sel]),      64'(exp_wc));
        check("aborted",     64'(aborted[sel]), 64'(exp_ab));
        check("seeded",      64'(saw_seed),     64'(exp_seed));
        check("tlast_beats", 64'(last_hs),      64'((!exp_ab && len > 0) ? 1 : 0));
        check("tvalid_done", 64'(tvalid[sel]),  64'd0);
        if (pct == 100 && abort_after < 0) begin
            check("done_latency", 64'(done_rel),
                  64'((len == 0) ? 1 : ((exp_seed ? 3 : 1) + len)));
            if (len > 0) check("first_valid", 64'(first_v), 64'(exp_seed ? 3 : 1));
        end
        @(negedge clk);
        check("busy_after", 64'(busy[sel]),    64'd0);
        check("done_pulse", 64'(done[sel]),    64'd0);
        check("ab_held",    64'(aborted[sel]), 64'(exp_ab));

        if (len > 0) begin
            next_idx[sel] = start_idx + hs;
            primed_m[sel] = 1'b1;
        end
    endtask

    initial begin
        int k;
        int sel, len, pct;
        tbl[0] = '{1,   8, 100, -1,  8, 1'b0, 1'b1};
        tbl[1] = '{1,  16,  50, -1, 16, 1'b0, 1'b1};
        tbl[2] = '{0,   5, 100, -1,  5, 1'b0, 1'b1};
        tbl[3] = '{0,   5, 100, -1,  5, 1'b0, 1'b0};
        tbl[4] = '{0,   0, 100, -1,  0, 1'b0, 1'b0};
        tbl[5] = '{1,   0, 100, -1,  0, 1'b0, 1'b0};
        tbl[6] = '{1, 100,  70,  3,  4, 1'b1, 1'b1};
        tbl[7] = '{0,  20,  60,  5,  6, 1'b1, 1'b0};
        tbl[8] = '{0,   4,  50, -1,  4, 1'b0, 1'b0};
        tbl[9] = '{1,   1,  30, -1,  1, 1'b0, 1'b1};

        build_words();
        do_reset();

        for (int i = 0; i < 10; i++) begin
            run_burst(tbl[i].sel, tbl[i].len, tbl[i].pct, tbl[i].abort_after,
                      tbl[i].exp_wc, tbl[i].exp_ab, tbl[i].exp_seed);
        end

        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(1));
            len = int'($urandom_range(12, 1));
            pct = int'($urandom_range(90, 30));
            run_burst(sel, len, pct, -1, len, 1'b0, (sel == 1) || !primed_m[sel]);
        end

        // Abort during PRIME on an unprimed RESEED=0 controller.
        do_reset();
        start[0] = 1'b1;
        blen[0]  = LW'(10);
        @(negedge clk);
        start[0] = 1'b0;
        check("a_seed",     64'(prbs_rst[0]), 64'd1);
        @(negedge clk);
        check("a_prime_en", 64'(prbs_en[0]),  64'd1);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("a_done",     64'(done[0]),     64'd1);
        check("a_aborted",  64'(aborted[0]),  64'd1);
        check("a_tvalid",   64'(tvalid[0]),   64'd0);
        check("a_wc",       64'(wc[0]),       64'd0);
        @(negedge clk);
        primed_m[0] = 1'b0;
        run_burst(0, 3, 100, -1, 3, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a stalled burst.
        tready[1] = 1'b0;
        start[1]  = 1'b1;
        blen[1]   = LW'(10);
        @(negedge clk);
        start[1] = 1'b0;
        k = 0;
        while (!tvalid[1] && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("b_valid", 64'(tvalid[1]), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("b_tvalid",   64'(tvalid[1]),   64'd0);
        check("b_prbs_rst", 64'(prbs_rst[1]), 64'd1);
        check("b_busy",     64'(busy[1]),     64'd0);
        check("b_wc",       64'(wc[1]),       64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("b_rel_prbs_rst", 64'(prbs_rst[1]), 64'd0);
        primed_m[0] = 1'b0; primed_m[1] = 1'b0;
        next_idx[0] = 0;    next_idx[1] = 0;
        run_burst(1, 3, 100, -1, 3, 1'b0, 1'b1);
        run_burst(0, 2, 100, -1, 2, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_burst_ctrl.md
# lfsr_prbs_burst_ctrl

Sequencer that owns one `lfsr_prbs` generator instance and turns its free-running output into finite, AXI-stream framed bursts of PRBS words. It reseeds and primes the generator, advances it only on accepted beats (so backpressure never skips or repeats a word), marks the final beat, and reports completion. It sits between a test/BERT control register block and the PRBS datapath feeding a serializer or loopback checker.

## Interface
- `DATA_WIDTH`, 64, width of generator output and stream data
- `LEN_WIDTH`, 16, width of burst length and word counter
- `RESEED`, 1, 1 = reseed generator at every burst start; 0 = continue sequence across bursts (reseed only after reset)
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle burst request, sampled in IDLE only
- `burst_len`  in  LEN_WIDTH  words in burst, captured with `start`
- `abort`  in  1  terminate current burst early
- `prbs_rst`  out  1  synchronous reset to generator
- `prbs_enable`  out  1  advance generator one word
- `prbs_data`  in  DATA_WIDTH  generator `data_out`
- `m_axis_tdata`  out  DATA_WIDTH  stream data
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready
- `m_axis_tlast`  out  1  final beat of burst
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at burst end
- `aborted`  out  1  status of last burst, valid from `done` until next `start`
- `word_count`  out  LEN_WIDTH  beats accepted in current/last burst

## Operation
- States: IDLE, SEED, PRIME, SEND, DONE.
- IDLE: `start`=1 captures `burst_len`, clears `word_count` and `aborted`. If `burst_len`==0 -> DONE. Else if RESEED=1 or generator unprimed -> SEED. Else -> SEND.
- SEED (1 cycle): `prbs_rst`=1 -> PRIME.
- PRIME (1 cycle): `prbs_enable`=1; sets internal `primed` flag -> SEND. After PRIME, `prbs_data` holds word 0 of the sequence.
- SEND: `m_axis_tvalid`=1, `m_axis_tdata`=`prbs_data` (direct), `prbs_enable`=`m_axis_tvalid & m_axis_tready` (combinational). Each handshake increments `word_count`.
- `m_axis_tlast`=1 when `word_count`==captured length-1 and abort not latched. Handshake with tlast -> DONE.
- Abort: `abort` in SEED or PRIME -> DONE immediately, `aborted`=1, `primed` cleared (generator state undefined). `abort` in SEND is latched; if no beat is pending, i.e. tvalid not yet presented, this cannot occur since tvalid is high throughout SEND; burst ends after the next handshake (that beat carries tlast=0), `aborted`=1 -> DONE. AXI rule kept: tvalid/tdata/tlast never change while tvalid=1 and tready=0, except that a latched abort does not lower tlast once asserted; a beat already showing tlast completes normally, `aborted`=0.
- `abort` in IDLE/DONE ignored. `start` while `busy` ignored.
- DONE (1 cycle): `done`=1 -> IDLE.
- RESEED=0: bursts continue the sequence exactly; unaccepted words are never consumed.

## Timing
- Reset values: state IDLE, `prbs_rst`=1 (generator held while controller in reset; drops to 0 first cycle after release), `prbs_enable`=0, tvalid=0, tlast=0, `busy`=0, `done`=0, `aborted`=0, `word_count`=0, `primed`=0.
- `start` at edge N: SEED in cycle N+1, PRIME N+2, first tvalid N+3. Primed with RESEED=0: tvalid in N+1.
- With tready held 1, one word per cycle; burst of L words: `done` high in cycle N+3+L (reseed path).
- `busy` rises the cycle after `start`, falls the cycle after `done`.
- All outputs registered except `prbs_enable` and `m_axis_tdata` in SEND.
- `rst` mid-burst: immediate return to reset values; tvalid drops asynchronously.

## Test plan
- RESEED=1, burst_len=8, tready=1: `start` at cycle 0 -> prbs_rst cycle 1, tvalid cycles 3-10, tlast cycle 10 only, `done` cycle 11, `word_count`=8, data matches PRBS31 model words 0-7.
- Backpressure: burst_len=16, tready random 50%: exactly 16 handshakes, data words 0-15 in order, no repeats or gaps, tdata stable while stalled.
- RESEED=0: two bursts of 5 -> second burst starts without prbs_rst, carries words 5-9; `done` pulses twice.
- burst_len=0: `done` 1 cycle after `start`, no tvalid, no prbs_rst, `word_count`=0.
- Abort: burst_len=100, abort after 3rd handshake with tready=0 -> exactly one more beat (tlast=0), `word_count`=4, `aborted`=1; abort during PRIME -> no beats, next burst with RESEED=0 reseeds.
- Async rst asserted mid-SEND with tready=0 -> tvalid 0 immediately, `prbs_rst`=1, `busy`=0; new burst afterwards starts from word 0.
